// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM sequencing RV64I-subset instructions over a shared datapath and one memory port.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit EN_JAL      = 1'b1,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             halt,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             reg_write,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [RET_W-1:0] retired,
    output logic [3:0]       state_dbg
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_WB_ALU = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_FAULT  = 4'd11
    } state_t;

    localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] LIMIT = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           r_state, w_next;
    logic [WW-1:0]    r_wait;
    logic [RET_W-1:0] r_retired;
    logic             r_bus_error;
    logic             w_req, w_rd, w_wr, w_iord, w_irw, w_pcw, w_br, w_asb, w_rw, w_ill;
    logic [1:0]       w_pcs, w_aop, w_wbs;
    logic             w_wait, w_timeout, w_retire;

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        w_iord   = 1'b0;
        w_irw    = 1'b0;
        w_pcw    = 1'b0;
        w_br     = 1'b0;
        w_pcs    = 2'b00;
        w_asb    = 1'b0;
        w_aop    = 2'b00;
        w_wbs    = 2'b00;
        w_rw     = 1'b0;
        w_ill    = 1'b0;
        w_retire = 1'b0;
        unique case (r_state)
            S_FETCH: if (!halt) begin
                w_req = 1'b1;
                w_rd  = 1'b1;
                if (mem_ready) begin
                    w_irw  = 1'b1;
                    w_pcw  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: case (opcode)
                7'b0110011: w_next = S_EXEC_R;
                7'b0010011: w_next = S_EXEC_I;
                7'b0000011,
                7'b0100011: w_next = S_ADDR;
                7'b1100011: w_next = S_BRANCH;
                7'b1101111: begin
                    w_ill  = !EN_JAL;
                    w_next = EN_JAL ? S_JUMP : S_FETCH;
                end
                default: begin
                    w_ill  = 1'b1;
                    w_next = S_FETCH;
                end
            endcase
            S_EXEC_R: begin
                w_aop  = 2'b10;
                w_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_asb  = 1'b1;
                w_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_rw     = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_ADDR: begin
                w_asb  = 1'b1;
                w_next = (opcode == 7'b0100011) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_req  = 1'b1;
                w_rd   = 1'b1;
                w_iord = 1'b1;
                w_next = mem_ready ? S_WB_MEM : S_MEM_RD;
            end
            S_WB_MEM: begin
                w_rw     = 1'b1;
                w_wbs    = 2'b01;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEM_WR: begin
                w_req    = 1'b1;
                w_wr     = 1'b1;
                w_iord   = 1'b1;
                w_retire = mem_ready;
                w_next   = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                w_aop    = 2'b01;
                w_br     = 1'b1;
                w_pcs    = 2'b01;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                w_pcw    = 1'b1;
                w_pcs    = 2'b10;
                w_rw     = 1'b1;
                w_wbs    = 2'b10;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FETCH;
        endcase
        // a stalled access that exhausts its wait budget overrides every other transition
        w_wait    = w_req && !mem_ready;
        w_timeout = (MEM_TIMEOUT > 0) && w_wait && (r_wait == LIMIT);
        if (w_timeout) w_next = S_FAULT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_FETCH;
            r_wait      <= '0;
            r_retired   <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait ? r_wait + 1'b1 : '0;
            if (w_retire) r_retired <= r_retired + 1'b1;
            if (w_timeout) r_bus_error <= 1'b1;
        end
    end

    // strobes are gated so they fall the instant reset_n drops, not at the next edge
    assign {mem_req, mem_read, mem_write, iord, ir_write, pc_write, branch, pc_src,
            alu_src_b, alu_op, wb_sel, reg_write, illegal_instr} = reset_n ?
           {w_req, w_rd, w_wr, w_iord, w_irw, w_pcw, w_br, w_pcs, w_asb, w_aop, w_wbs, w_rw, w_ill} : '0;
    assign bus_error = r_bus_error;
    assign retired   = r_retired;
    assign state_dbg = r_state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-cycle scoreboard of control strobes for two parameterisations.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, mem_ready, halt;
    logic [6:0] opcode;

    logic       a_req, a_rd, a_wr, a_iord, a_irw, a_pcw, a_br, a_asb, a_rw, a_ill, a_berr;
    logic [1:0] a_pcs, a_aop, a_wbs;
    logic [3:0] a_ret, a_st;
    logic       b_req, b_rd, b_wr, b_iord, b_irw, b_pcw, b_br, b_asb, b_rw, b_ill, b_berr;
    logic [1:0] b_pcs, b_aop, b_wbs;
    logic [3:0] b_ret, b_st;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .EN_JAL(1'b1), .RET_W(4)) dut_a (
        .clk(clk), .reset_n(rst_a), .opcode(opcode), .mem_ready(mem_ready), .halt(halt),
        .mem_req(a_req), .mem_read(a_rd), .mem_write(a_wr), .iord(a_iord), .ir_write(a_irw),
        .pc_write(a_pcw), .branch(a_br), .pc_src(a_pcs), .alu_src_b(a_asb), .alu_op(a_aop),
        .wb_sel(a_wbs), .reg_write(a_rw), .illegal_instr(a_ill), .bus_error(a_berr),
        .retired(a_ret), .state_dbg(a_st));

    multicycle_control_unit #(.MEM_TIMEOUT(16), .EN_JAL(1'b0), .RET_W(4)) dut_b (
        .clk(clk), .reset_n(rst_b), .opcode(opcode), .mem_ready(mem_ready), .halt(halt),
        .mem_req(b_req), .mem_read(b_rd), .mem_write(b_wr), .iord(b_iord), .ir_write(b_irw),
        .pc_write(b_pcw), .branch(b_br), .pc_src(b_pcs), .alu_src_b(b_asb), .alu_op(b_aop),
        .wb_sel(b_wbs), .reg_write(b_rw), .illegal_instr(b_ill), .bus_error(b_berr),
        .retired(b_ret), .state_dbg(b_st));

    logic [20:0] a_ctl, b_ctl;
    assign a_ctl = {a_st, a_req, a_rd, a_wr, a_iord, a_irw, a_pcw, a_br, a_pcs, a_asb, a_aop, a_wbs, a_rw, a_ill, a_berr};
    assign b_ctl = {b_st, b_req, b_rd, b_wr, b_iord, b_irw, b_pcw, b_br, b_pcs, b_asb, b_aop, b_wbs, b_rw, b_ill, b_berr};

    // state _ req rd wr iord _ irw pcw br _ pc_src _ alu_src_b _ alu_op _ wb_sel _ reg_write ill bus_error
    localparam logic [20:0] ZERO    = 21'b0000_0000_000_00_0_00_00_000;
    localparam logic [20:0] F_HALT  = 21'b0000_0000_000_00_0_00_00_000;
    localparam logic [20:0] F_WAIT  = 21'b0000_1100_000_00_0_00_00_000;
    localparam logic [20:0] F_RDY   = 21'b0000_1100_110_00_0_00_00_000;
    localparam logic [20:0] DEC     = 21'b0001_0000_000_00_0_00_00_000;
    localparam logic [20:0] DEC_ILL = 21'b0001_0000_000_00_0_00_00_010;
    localparam logic [20:0] EXR     = 21'b0010_0000_000_00_0_10_00_000;
    localparam logic [20:0] EXI     = 21'b0011_0000_000_00_1_00_00_000;
    localparam logic [20:0] WBA     = 21'b0100_0000_000_00_0_00_00_100;
    localparam logic [20:0] ADR     = 21'b0101_0000_000_00_1_00_00_000;
    localparam logic [20:0] MRD     = 21'b0110_1101_000_00_0_00_00_000;
    localparam logic [20:0] WBM     = 21'b0111_0000_000_00_0_00_01_100;
    localparam logic [20:0] MWR     = 21'b1000_1011_000_00_0_00_00_000;
    localparam logic [20:0] BR      = 21'b1001_0000_001_01_0_01_00_000;
    localparam logic [20:0] JMP     = 21'b1010_0000_010_10_0_00_10_100;
    localparam logic [20:0] FLT     = 21'b1011_0000_000_00_0_00_00_001;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    typedef struct {
        logic        sel;
        logic [20:0] ctl;
        logic [3:0]  ret;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic cur      = 1'b0;

    always @(negedge clk) begin
        exp_t        e;
        logic [20:0] act;
        logic [3:0]  ar;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = e.sel ? b_ctl : a_ctl;
            ar  = e.sel ? b_ret : a_ret;
            n_checks++;
            if ({act, ar} !== {e.ctl, e.ret}) begin
                n_fail++;
                $display("FAIL %s dut=%0d: got ctl=%b retired=%0d, want ctl=%b retired=%0d",
                         e.tag, e.sel, act, ar, e.ctl, e.ret);
            end
        end
    end

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", tag, got, want);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] op, input logic rdy, input logic h,
                        input logic [20:0] ec, input logic [3:0] er);
        exp_t e;
        opcode    = op;
        mem_ready = rdy;
        halt      = h;
        e.sel = cur;
        e.ctl = ec;
        e.ret = er;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        mem_ready = 1'b0;
        halt = 1'b0;
        opcode = 7'd0;
        @(posedge clk);
        #1;
        check("reset_state", a_ctl, ZERO);
        step("reset0", OP_R, 1'b0, 1'b0, ZERO, 4'd0);
        step("reset1", OP_R, 1'b1, 1'b0, ZERO, 4'd0);
        rst_a = 1'b1;
        step("r_fetch", OP_R, 1'b1, 1'b0, F_RDY, 4'd0);
        step("r_decode", OP_R, 1'b1, 1'b0, DEC, 4'd0);
        step("r_exec", OP_R, 1'b1, 1'b0, EXR, 4'd0);
        step("r_wb", OP_R, 1'b1, 1'b0, WBA, 4'd0);
        step("ld_fwait", OP_LD, 1'b0, 1'b0, F_WAIT, 4'd1);
        step("ld_fetch", OP_LD, 1'b1, 1'b0, F_RDY, 4'd1);
        step("ld_decode", OP_LD, 1'b0, 1'b0, DEC, 4'd1);
        step("ld_addr", OP_LD, 1'b1, 1'b0, ADR, 4'd1);
        for (int i = 0; i < 3; i++) step("ld_memwait", OP_LD, 1'b0, 1'b0, MRD, 4'd1);
        step("ld_memrdy", OP_LD, 1'b1, 1'b0, MRD, 4'd1);
        step("ld_wb", OP_LD, 1'b1, 1'b0, WBM, 4'd1);
        step("ill_fetch", OP_SYS, 1'b1, 1'b0, F_RDY, 4'd2);
        step("ill_decode", OP_SYS, 1'b1, 1'b0, DEC_ILL, 4'd2);
        step("st_fetch", OP_ST, 1'b1, 1'b0, F_RDY, 4'd2);
        step("st_decode", OP_ST, 1'b1, 1'b0, DEC, 4'd2);
        step("st_addr", OP_ST, 1'b1, 1'b0, ADR, 4'd2);
        step("st_memwait", OP_ST, 1'b0, 1'b0, MWR, 4'd2);
        step("st_memrdy", OP_ST, 1'b1, 1'b0, MWR, 4'd2);
        step("i_fetch", OP_I, 1'b1, 1'b0, F_RDY, 4'd3);
        step("i_decode", OP_I, 1'b1, 1'b0, DEC, 4'd3);
        step("i_exec", OP_I, 1'b1, 1'b0, EXI, 4'd3);
        step("i_wb", OP_I, 1'b1, 1'b0, WBA, 4'd3);
        step("jal_fetch", OP_JAL, 1'b1, 1'b0, F_RDY, 4'd4);
        step("jal_decode", OP_JAL, 1'b1, 1'b0, DEC, 4'd4);
        step("jal_jump", OP_JAL, 1'b1, 1'b0, JMP, 4'd4);
        step("halt0", OP_R, 1'b1, 1'b1, F_HALT, 4'd5);
        step("halt1", OP_R, 1'b1, 1'b1, F_HALT, 4'd5);
        rst_a = 1'b0;
        step("reset_retired", OP_BR, 1'b1, 1'b0, ZERO, 4'd0);
        rst_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step("br_fetch", OP_BR, 1'b1, 1'b0, F_RDY, 4'(i));
            step("br_decode", OP_BR, 1'b1, 1'b0, DEC, 4'(i));
            step("br_exec", OP_BR, 1'b1, 1'b0, BR, 4'(i));
        end
        step("ret_wrap", OP_BR, 1'b1, 1'b1, F_HALT, 4'd0);
        step("st2_fetch", OP_ST, 1'b1, 1'b0, F_RDY, 4'd0);
        step("st2_decode", OP_ST, 1'b1, 1'b0, DEC, 4'd0);
        step("st2_addr", OP_ST, 1'b1, 1'b0, ADR, 4'd0);
        step("st2_memwait", OP_ST, 1'b0, 1'b0, MWR, 4'd0);
        rst_a = 1'b0;
        step("st2_abort", OP_ST, 1'b1, 1'b0, ZERO, 4'd0);
        rst_a = 1'b1;
        for (int i = 0; i < 4; i++) step("to_wait", OP_R, 1'b0, 1'b0, F_WAIT, 4'd0);
        step("fault0", OP_R, 1'b1, 1'b0, FLT, 4'd0);
        check("expired_wait", 21'({a_berr, a_st}), 21'({1'b1, 4'd11}));
        step("fault1", OP_R, 1'b1, 1'b0, FLT, 4'd0);
        rst_a = 1'b0;
        step("fault_reset", OP_R, 1'b0, 1'b0, ZERO, 4'd0);
        rst_a = 1'b1;
        step("post_fault", OP_R, 1'b0, 1'b1, F_HALT, 4'd0);
        rst_a = 1'b0;
        rst_b = 1'b1;
        cur = 1'b1;
        step("nojal_fetch", OP_JAL, 1'b1, 1'b0, F_RDY, 4'd0);
        step("nojal_decode", OP_JAL, 1'b1, 1'b0, DEC_ILL, 4'd0);
        step("nojal_after", OP_JAL, 1'b1, 1'b1, F_HALT, 4'd0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
